// File: rtl/sarlock_key_loader.sv
// Bit-serial SARLock key loader: MSB-first shift, even-parity check, atomic commit to keyinput.
// Optional lockout after MAX_FAIL consecutive failed loads: define SARLOCK_KEY_LOCKOUT_EN.
module sarlock_key_loader #(
  parameter int KEY_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_FAIL       = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 sdi,
  input  logic                 sdi_valid,
  output logic                 sdi_ready,
  output logic [KEY_WIDTH-1:0] keyinput,
  output logic                 key_valid,
  output logic                 busy,
  output logic                 load_err,
  output logic                 locked_out
);

  localparam int CNT_W  = $clog2(KEY_WIDTH);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(KEY_WIDTH - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
`ifdef SARLOCK_KEY_LOCKOUT_EN
  localparam logic [1:0] ST_LOCKED = 2'd3;
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);
`endif

  function automatic logic even_parity_ok(input logic [KEY_WIDTH-1:0] key, input logic pbit);
    return ~(^{key, pbit});
  endfunction

  logic [1:0]           state_q, state_d;
  logic [KEY_WIDTH-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic [KEY_WIDTH-1:0] keyinput_q, keyinput_d;
  logic                 key_valid_q, key_valid_d;
  logic                 load_err_q, load_err_d;
  logic                 sdi_ready_q, sdi_ready_d;
  logic                 busy_q, busy_d;
`ifdef SARLOCK_KEY_LOCKOUT_EN
  logic [FAIL_W-1:0]    fail_cnt_q, fail_cnt_d;
  logic                 locked_q, locked_d;
`endif

  logic xfer_s;
  logic start_s, shift_s, parity_s, timeout_s, bad_state_s;
  logic pass_s, fail_s;

  assign xfer_s = sdi_valid & sdi_ready_q;

  // Decode what happens this cycle; a load_start restart outranks any same-cycle transfer.
  always_comb begin
    start_s     = 1'b0;
    shift_s     = 1'b0;
    parity_s    = 1'b0;
    timeout_s   = 1'b0;
    bad_state_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start_s = load_start;
      end
      ST_SHIFT: begin
        start_s   = load_start;
        shift_s   = ~load_start & xfer_s;
        timeout_s = ~load_start & ~xfer_s & (idle_cnt_q == IDLE_LAST);
      end
      ST_PARITY: begin
        start_s   = load_start;
        parity_s  = ~load_start & xfer_s;
        timeout_s = ~load_start & ~xfer_s & (idle_cnt_q == IDLE_LAST);
      end
`ifdef SARLOCK_KEY_LOCKOUT_EN
      ST_LOCKED: begin
        start_s = 1'b0;
      end
`endif
      default: begin
        bad_state_s = 1'b1;
      end
    endcase
  end

  // Next-state and output computation; keyinput only moves on commit, fail or reset.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    bit_cnt_d   = bit_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    keyinput_d  = keyinput_q;
    key_valid_d = key_valid_q;
    load_err_d  = load_err_q;
`ifdef SARLOCK_KEY_LOCKOUT_EN
    fail_cnt_d  = fail_cnt_q;
`endif
    pass_s = parity_s & even_parity_ok(shadow_q, sdi);
    fail_s = timeout_s | (parity_s & ~even_parity_ok(shadow_q, sdi));

    if (start_s) begin
      state_d    = ST_SHIFT;
      shadow_d   = '0;
      bit_cnt_d  = '0;
      idle_cnt_d = '0;
      load_err_d = 1'b0;
    end else if (fail_s) begin
      state_d     = ST_IDLE;
      keyinput_d  = '0;
      key_valid_d = 1'b0;
      load_err_d  = 1'b1;
      idle_cnt_d  = timeout_s ? IDLE_MAX : '0;
`ifdef SARLOCK_KEY_LOCKOUT_EN
      if (fail_cnt_q == FAIL_LAST) begin
        fail_cnt_d = FAIL_MAX;
        state_d    = ST_LOCKED;
      end else begin
        fail_cnt_d = fail_cnt_q + FAIL_W'(1);
      end
`endif
    end else if (pass_s) begin
      state_d     = ST_IDLE;
      keyinput_d  = shadow_q;
      key_valid_d = 1'b1;
      idle_cnt_d  = '0;
`ifdef SARLOCK_KEY_LOCKOUT_EN
      fail_cnt_d  = '0;
`endif
    end else if (shift_s) begin
      shadow_d   = {shadow_q[KEY_WIDTH-2:0], sdi};
      idle_cnt_d = '0;
      if (bit_cnt_q == BIT_LAST) begin
        state_d = ST_PARITY;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end else if (busy_q) begin
      // Timeout fires at IDLE_LAST, so this increment cannot overflow.
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end else begin
      state_d = bad_state_s ? ST_IDLE : state_q;
    end

    sdi_ready_d = (state_d == ST_SHIFT) || (state_d == ST_PARITY);
    busy_d      = (state_d == ST_SHIFT) || (state_d == ST_PARITY);
`ifdef SARLOCK_KEY_LOCKOUT_EN
    locked_d    = (state_d == ST_LOCKED);
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      bit_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      keyinput_q  <= '0;
      key_valid_q <= 1'b0;
      load_err_q  <= 1'b0;
      sdi_ready_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SARLOCK_KEY_LOCKOUT_EN
      fail_cnt_q  <= '0;
      locked_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      bit_cnt_q   <= bit_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      keyinput_q  <= keyinput_d;
      key_valid_q <= key_valid_d;
      load_err_q  <= load_err_d;
      sdi_ready_q <= sdi_ready_d;
      busy_q      <= busy_d;
`ifdef SARLOCK_KEY_LOCKOUT_EN
      fail_cnt_q  <= fail_cnt_d;
      locked_q    <= locked_d;
`endif
    end
  end

  assign sdi_ready = sdi_ready_q;
  assign keyinput  = keyinput_q;
  assign key_valid = key_valid_q;
  assign busy      = busy_q;
  assign load_err  = load_err_q;
`ifdef SARLOCK_KEY_LOCKOUT_EN
  assign locked_out = locked_q;
`else
  assign locked_out = 1'b0;
`endif

endmodule
